// File: rtl/dmem_ctrl_pkg.sv
// Shared types for the data-memory burst controller.
package dmem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam int DEFAULT_LEN_W = 8;

endpackage

// File: rtl/dmem_rd_skid.sv
// One-entry registered read output stage with valid/ready handshake.
module dmem_rd_skid #(
  parameter int DWIDTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DWIDTH-1:0] in_data,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DWIDTH-1:0] out_data,
  output logic              take
);

  // A new word can enter whenever the slot is empty or being drained this cycle.
  assign take = in_valid && (!out_valid || out_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (take) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/dmem_burst_ctrl.sv
// Burst load/store front-end for data_ram; one RAM word per cycle, wrapping addresses.
// Optional DMEM_BOUND_CHK_EN rejects bursts that would cross the top of memory and pulses err.
module dmem_burst_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int DWIDTH     = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int LEN_W      = DEFAULT_LEN_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_we,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_W-1:0]      cmd_len,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DWIDTH-1:0]     wr_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DWIDTH-1:0]     rd_data,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DWIDTH-1:0]     ram_data,
  output logic                  ram_we,
  input  logic [DWIDTH-1:0]     ram_dout,
  output logic                  err
);

  state_t                state;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [LEN_W-1:0]      count;
  logic                  rd_take;
  logic                  cmd_ok;

`ifdef DMEM_BOUND_CHK_EN
  logic [ADDR_WIDTH:0] end_addr;

  // One extra bit catches bursts whose last word lies past the top address.
  assign end_addr = {1'b0, cmd_addr} + (ADDR_WIDTH + 1)'(cmd_len);
  assign cmd_ok   = !end_addr[ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else begin
      err <= (state == IDLE) && cmd_valid && !cmd_ok;
    end
  end
`else
  assign cmd_ok = 1'b1;
  assign err    = 1'b0;
`endif

  assign cmd_ready = (state == IDLE);
  assign wr_ready  = (state == WRITE);
  assign busy      = (state != IDLE);
  assign ram_addr  = (state == WRITE || state == READ) ? cur_addr : '0;
  assign ram_data  = (state == WRITE) ? wr_data : '0;
  assign ram_we    = !rst && (state == WRITE) && wr_valid;

  dmem_rd_skid #(
    .DWIDTH(DWIDTH)
  ) u_rd_skid (
    .clk      (clk),
    .rst      (rst),
    .in_valid (state == READ),
    .in_data  (ram_dout),
    .out_ready(rd_ready),
    .out_valid(rd_valid),
    .out_data (rd_data),
    .take     (rd_take)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cur_addr <= '0;
      count    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ok) begin
            cur_addr <= cmd_addr;
            count    <= cmd_len;
            state    <= cmd_we ? WRITE : READ;
          end
        end
        WRITE: begin
          if (wr_valid) begin
            cur_addr <= cur_addr + ADDR_WIDTH'(1);
            if (count == '0) state <= IDLE;
            else             count <= count - LEN_W'(1);
          end
        end
        READ: begin
          if (rd_take) begin
            cur_addr <= cur_addr + ADDR_WIDTH'(1);
            if (count == '0) state <= DRAIN;
            else             count <= count - LEN_W'(1);
          end
        end
        DRAIN: begin
          if (!rd_valid || rd_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
